// File: rtl/p_emap_gather.sv
// p_emap_gather
//   Index-driven gather engine. It splits a vector of element indices into chunks
//   of N_OUT slots and processes one chunk per cycle through a three-stage
//   pipeline:
//     stage 1 : index -> (word, lane) decode
//     stage 2 : registered memory read of mem[word]
//     stage 3 : lane select into the registered output_row
//   Chunk c takes its indices from the slots just below the top slot, i.e. from
//   slots N_IDX-N_OUT*(c+1) .. N_IDX-N_OUT*c-1. An index of all ones is a hole:
//   its element comes out as zero.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             job request, accepted only while busy=0
//   col_nos           N_IDX packed indices (slot k at bits k*ELEM_W)
//   no_of_multiples   requested chunk count, clamped to 1..N_CHUNKS
//   wr_en/addr/data   memory write port, usable at any time (read-first)
//   output_row        gathered row, N_OUT elements
//   out_valid/ready   output handshake; ready low stalls the whole pipeline
//   out_last          marks the final row of a job
//   busy              high from accept until the final row handshakes
//   done              one-cycle pulse after the final row handshakes
//   oob_err           (bounds-check build only) sticky out-of-range flag
//
// Build option
//   P_EMAP_GATHER_BOUNDS_CHECK_EN : when defined, a valid index whose word
//   address is >= DEPTH yields a zero element and sets oob_err. When undefined,
//   the word address simply wraps to clog2(DEPTH) bits.

module p_emap_gather #(
  parameter int N_OUT   = 16,
  parameter int N_IDX   = 32,
  parameter int ELEM_W  = 32,
  parameter int N_UNITS = 8,
  parameter int DEPTH   = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [N_IDX*ELEM_W-1:0]   col_nos,
  input  logic [31:0]               no_of_multiples,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [N_UNITS*ELEM_W-1:0] wr_data,
  output logic [N_OUT*ELEM_W-1:0]   output_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
`ifdef P_EMAP_GATHER_BOUNDS_CHECK_EN
  ,
  output logic                      oob_err
`endif
);

  localparam int N_CHUNKS = N_IDX / N_OUT;
  localparam int AW       = $clog2(DEPTH);
  localparam int LSH      = $clog2(N_UNITS);            // lane bits in an index
  localparam int LW       = (LSH > 0) ? LSH : 1;
  localparam int CW       = $clog2(N_CHUNKS + 1);       // holds 0..N_CHUNKS
  localparam int SW       = (N_IDX > 1) ? $clog2(N_IDX) : 1;
  localparam int WORD_W   = N_UNITS * ELEM_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t                    state_reg;
  logic [N_IDX*ELEM_W-1:0]   cols_reg;
  logic [CW-1:0]             m_reg;
  logic [CW-1:0]             chunk_reg;
  logic [CW-1:0]             m_eff;

  // Global pipeline advance: everything holds while a row waits on out_ready.
  logic adv;
  logic issue;
  logic issue_last;

  assign adv        = !(out_valid && !out_ready);
  assign issue      = (state_reg == S_ISSUE) && adv;
  assign issue_last = (chunk_reg == m_reg - CW'(1));

  always_comb begin
    if (no_of_multiples == 32'd0)
      m_eff = CW'(1);
    else if (no_of_multiples > 32'(N_CHUNKS))
      m_eff = CW'(N_CHUNKS);
    else
      m_eff = CW'(no_of_multiples);
  end

  // ---------------------------------------------------------------------------
  // Stage 0 (combinational): pick this chunk's indices and decode them
  // ---------------------------------------------------------------------------
  logic [ELEM_W-1:0]            slot_arr [N_IDX];
  logic [31:0]                  slot_base;
  logic [N_OUT-1:0][AW-1:0]     s0_addr;
  logic [N_OUT-1:0][LW-1:0]     s0_lane;
  logic [N_OUT-1:0]             s0_ok;
`ifdef P_EMAP_GATHER_BOUNDS_CHECK_EN
  logic [N_OUT-1:0]             s0_oob;
`endif

  generate
    for (genvar gi = 0; gi < N_IDX; gi++) begin : g_slot
      assign slot_arr[gi] = cols_reg[gi*ELEM_W +: ELEM_W];
    end
  endgenerate

  assign slot_base = 32'(N_IDX) - 32'(N_OUT) * (32'(chunk_reg) + 32'd1);

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_dec
      logic [SW-1:0]     sel;
      logic [ELEM_W-1:0] idx;
      logic [ELEM_W-1:0] word_full;
      logic              hole;

      assign sel       = SW'(slot_base + 32'(gi));
      assign idx       = slot_arr[sel];
      assign word_full = idx >> LSH;
      assign hole      = (idx == {ELEM_W{1'b1}});
      assign s0_addr[gi] = word_full[AW-1:0];
      assign s0_lane[gi] = (LSH > 0) ? idx[LW-1:0] : '0;
`ifdef P_EMAP_GATHER_BOUNDS_CHECK_EN
      assign s0_oob[gi] = !hole && (word_full >= ELEM_W'(DEPTH));
      assign s0_ok[gi]  = !hole && !s0_oob[gi];
`else
      // Upper word bits are dropped on purpose: the address wraps.
      logic unused_hi;
      assign unused_hi = ^word_full[ELEM_W-1:AW];
      assign s0_ok[gi] = !hole;
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM and pipeline valid/last tracking
  // ---------------------------------------------------------------------------
  logic s1_valid, s1_last;
  logic s2_valid, s2_last;
  logic [N_OUT*ELEM_W-1:0] row_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cols_reg   <= '0;
      m_reg      <= '0;
      chunk_reg  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      output_row <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_ISSUE;
            cols_reg  <= col_nos;
            m_reg     <= m_eff;
            chunk_reg <= '0;
            busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (adv) begin
            if (issue_last)
              state_reg <= S_DRAIN;
            else
              chunk_reg <= chunk_reg + CW'(1);
          end
        end
        S_DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase

      if (adv) begin
        s1_valid   <= issue;
        s1_last    <= issue && issue_last;
        s2_valid   <= s1_valid;
        s2_last    <= s1_last;
        out_valid  <= s2_valid;
        out_last   <= s2_last;
        output_row <= row_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 / stage 2 per-element side data
  // ---------------------------------------------------------------------------
  logic [N_OUT-1:0][AW-1:0]   s1_addr;
  logic [N_OUT-1:0][LW-1:0]   s1_lane;
  logic [N_OUT-1:0]           s1_ok;
  logic [N_OUT-1:0][LW-1:0]   s2_lane;
  logic [N_OUT-1:0]           s2_ok;
  logic [N_OUT-1:0][WORD_W-1:0] s2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_addr <= '0;
      s1_lane <= '0;
      s1_ok   <= '0;
      s2_lane <= '0;
      s2_ok   <= '0;
    end else if (adv) begin
      s1_addr <= s0_addr;
      s1_lane <= s0_lane;
      s1_ok   <= s0_ok;
      s2_lane <= s1_lane;
      s2_ok   <= s1_ok;
    end
  end

  // Memory: contents are never reset. Reads use the pre-write value of a word
  // written in the same cycle.
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    if (adv) begin
      for (int j = 0; j < N_OUT; j++)
        s2_data[j] <= mem[s1_addr[j]];
    end
  end

  // Stage 3 lane select: lane 0 sits in the most significant element of a word.
  always_comb begin
    row_next = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (s2_ok[j])
        row_next[j*ELEM_W +: ELEM_W] =
          s2_data[j][(N_UNITS - 1 - int'(s2_lane[j]))*ELEM_W +: ELEM_W];
    end
  end

`ifdef P_EMAP_GATHER_BOUNDS_CHECK_EN
  // Sticky per job: cleared when a new job is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      oob_err <= 1'b0;
    else if (state_reg == S_IDLE && start)
      oob_err <= 1'b0;
    else if (issue && (|s0_oob))
      oob_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_p_emap_gather.sv
// tb_p_emap_gather
//   Directed bench for p_emap_gather at default parameters. Memory word w lane l
//   holds 32'hA000_0000 | (w << 8) | l, written for words 0..7, so every
//   expected element can be worked out by hand from its index.

module tb_p_emap_gather;

  localparam int N_OUT   = 16;
  localparam int N_IDX   = 32;
  localparam int ELEM_W  = 32;
  localparam int N_UNITS = 8;
  localparam int DEPTH   = 1024;
  localparam int RW      = N_OUT * ELEM_W;
  localparam int CWID    = N_IDX * ELEM_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [CWID-1:0] col_nos = '0;
  logic [31:0]     no_of_multiples = '0;
  logic            wr_en = 1'b0;
  logic [9:0]      wr_addr = '0;
  logic [255:0]    wr_data = '0;
  logic [RW-1:0]   output_row;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;
  logic            busy;
  logic            done;
`ifdef P_EMAP_GATHER_BOUNDS_CHECK_EN
  logic            oob_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  p_emap_gather #(
    .N_OUT  (N_OUT),
    .N_IDX  (N_IDX),
    .ELEM_W (ELEM_W),
    .N_UNITS(N_UNITS),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .col_nos        (col_nos),
    .no_of_multiples(no_of_multiples),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .output_row     (output_row),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done)
`ifdef P_EMAP_GATHER_BOUNDS_CHECK_EN
    ,
    .oob_err        (oob_err)
`endif
  );

  function automatic logic [31:0] mem_val(input int w, input int l);
    return 32'hA000_0000 | 32'(w << 8) | 32'(l);
  endfunction

  function automatic logic [31:0] exp_elem(input logic [31:0] idx);
    logic [31:0] w;
    if (idx == 32'hFFFF_FFFF) return '0;
    w = idx >> 3;
`ifdef P_EMAP_GATHER_BOUNDS_CHECK_EN
    if (w >= 32'd1024) return '0;
`endif
    return mem_val(int'(w & 32'd1023), int'(idx & 32'd7));
  endfunction

  function automatic logic [RW-1:0] exp_row(input logic [CWID-1:0] cols, input int c);
    logic [RW-1:0] r;
    r = '0;
    for (int j = 0; j < N_OUT; j++)
      r[j*32 +: 32] = exp_elem(cols[(N_IDX - N_OUT*(c+1) + j)*32 +: 32]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [CWID-1:0] cols, input logic [31:0] nm);
    col_nos         = cols;
    no_of_multiples = nm;
    start           = 1'b1;
    tick();
    start           = 1'b0;
    $display("job started: no_of_multiples=%0d", nm);
  endtask

  logic [CWID-1:0] cols1, cols2, cols3, cols6;
  logic [255:0]    wd;
  logic            seen;

  initial begin
    // Index tables
    for (int k = 0; k < 16; k++) begin
      cols1[(31-k)*32 +: 32] = 32'(16 + (k % 8));
      cols1[(15-k)*32 +: 32] = 32'(k);
      cols2[(31-k)*32 +: 32] = 32'(k * 3);
      cols2[(15-k)*32 +: 32] = 32'hFFFF_FFFF;
    end
    for (int s = 0; s < N_IDX; s++)
      cols3[s*32 +: 32] = 32'(s + 8);
    cols6 = cols3;
    cols6[31*32 +: 32] = 32'd8200;

    // Reset state
    tick();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_row", output_row, '0);
    tick();
    rst_n = 1'b1;

    // Load memory words 0..7
    for (int w = 0; w < 8; w++) begin
      for (int l = 0; l < 8; l++)
        wd[(7-l)*32 +: 32] = mem_val(w, l);
      wr_en   = 1'b1;
      wr_addr = 10'(w);
      wr_data = wd;
      tick();
    end
    wr_en = 1'b0;
    tick();

    // Single row, latency and done
    accept(cols1, 32'd1);
    chk("t1_busy", busy, 1'b1);
    tick();
    chk("t1_valid_c1", out_valid, 1'b0);
    tick();
    chk("t1_valid_c2", out_valid, 1'b0);
    tick();
    chk("t1_valid_c3", out_valid, 1'b1);
    chk("t1_row", output_row, exp_row(cols1, 0));
    chk("t1_elem15", output_row[511:480], 32'hA000_0200);
    chk("t1_last", out_last, 1'b1);
    chk("t1_done_early", done, 1'b0);
    tick();
    $display("row handshake: job 1 row 0");
    chk("t1_done", done, 1'b1);
    chk("t1_valid_after", out_valid, 1'b0);
    chk("t1_busy_after", busy, 1'b0);
    tick();
    chk("t1_done_pulse", done, 1'b0);

    // Two rows, second made of holes
    accept(cols2, 32'd2);
    tick();
    tick();
    tick();
    chk("t2_valid0", out_valid, 1'b1);
    chk("t2_row0", output_row, exp_row(cols2, 0));
    chk("t2_last0", out_last, 1'b0);
    tick();
    chk("t2_valid1", out_valid, 1'b1);
    chk("t2_row1", output_row, '0);
    chk("t2_last1", out_last, 1'b1);
    chk("t2_done_early", done, 1'b0);
    tick();
    $display("row handshake: job 2 rows 0,1");
    chk("t2_done", done, 1'b1);
    tick();

    // Backpressure on the first row
    out_ready = 1'b0;
    accept(cols3, 32'd2);
    tick();
    tick();
    tick();
    chk("t3_valid0", out_valid, 1'b1);
    chk("t3_row0", output_row, exp_row(cols3, 0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_valid", out_valid, 1'b1);
      chk("t3_hold_row", output_row, exp_row(cols3, 0));
      chk("t3_hold_last", out_last, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_valid1", out_valid, 1'b1);
    chk("t3_row1", output_row, exp_row(cols3, 1));
    chk("t3_last1", out_last, 1'b1);
    tick();
    $display("row handshake: job 3 rows 0,1");
    chk("t3_done", done, 1'b1);
    tick();

    // Chunk count clamps; back-to-back start in the done cycle
    accept(cols3, 32'd0);
    tick();
    tick();
    tick();
    chk("t4a_row", output_row, exp_row(cols3, 0));
    chk("t4a_last", out_last, 1'b1);
    tick();
    chk("t4a_done", done, 1'b1);
    accept(cols3, 32'd7);
    chk("t4b_busy", busy, 1'b1);
    tick();
    col_nos         = '1;
    no_of_multiples = 32'd1;
    start           = 1'b1;
    tick();
    start           = 1'b0;
    tick();
    chk("t4b_row0", output_row, exp_row(cols3, 0));
    chk("t4b_last0", out_last, 1'b0);
    tick();
    chk("t4b_row1", output_row, exp_row(cols3, 1));
    chk("t4b_last1", out_last, 1'b1);
    tick();
    chk("t4b_done", done, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid || busy) seen = 1'b1;
    end
    chk("t4b_ignored_start", seen, 1'b0);

    // Reset while issuing
    accept(cols3, 32'd2);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", busy, 1'b0);
    chk("t5_valid_rst", out_valid, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("t5_no_rows", seen, 1'b0);

    // Reset while a row is held
    out_ready = 1'b0;
    accept(cols3, 32'd2);
    tick();
    tick();
    tick();
    chk("t5b_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5b_row_rst", output_row, '0);
    chk("t5b_valid_rst", out_valid, 1'b0);
    chk("t5b_last_rst", out_last, 1'b0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("t5b_no_rows", seen, 1'b0);
    accept(cols1, 32'd1);
    tick();
    tick();
    tick();
    chk("t5c_row", output_row, exp_row(cols1, 0));
    chk("t5c_last", out_last, 1'b1);
    tick();
    chk("t5c_done", done, 1'b1);

    // Word address beyond DEPTH (index 8200 -> word 1025, lane 0)
    accept(cols6, 32'd1);
    tick();
    tick();
    tick();
`ifdef P_EMAP_GATHER_BOUNDS_CHECK_EN
    chk("t6_elem15", output_row[511:480], 32'h0);
    chk("t6_oob_err", oob_err, 1'b1);
`else
    chk("t6_elem15", output_row[511:480], 32'hA000_0100);
`endif
    chk("t6_row", output_row, exp_row(cols6, 0));
    tick();
    chk("t6_done", done, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/p_emap_gather.md
P_EMAP_GATHER -- requirements
Module: p_emap_gather

Interface
REQ-001 SHALL have parameter N_OUT, default 16, gathered elements per output row.
REQ-002 SHALL have parameter N_IDX, default 32, index slots in col_nos; must be an integer multiple of N_OUT; N_CHUNKS = N_IDX/N_OUT.
REQ-003 SHALL have parameter ELEM_W, default 32, element and index width.
REQ-004 SHALL have parameter N_UNITS, default 8, elements per memory word; must be a power of two.
REQ-005 SHALL have parameter DEPTH, default 1024, memory words.
REQ-006 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: start  in  1  job request; col_nos  in  N_IDX*ELEM_W  index vector; no_of_multiples  in  32  chunks to process.
REQ-008 SHALL have ports: wr_en  in  1; wr_addr  in  clog2(DEPTH); wr_data  in  N_UNITS*ELEM_W  memory write port.
REQ-009 SHALL have ports: output_row  out  N_OUT*ELEM_W; out_valid  out  1; out_ready  in  1; out_last  out  1; busy  out  1; done  out  1 (one-cycle pulse).

Function
REQ-010 SHALL accept a job when start=1 and busy=0, capturing col_nos and effective chunk count M = clamp(no_of_multiples, 1, N_CHUNKS); start while busy=1 is ignored.
REQ-011 SHALL implement FSM IDLE -> ISSUE (on accept) -> DRAIN (after chunk M-1 issued) -> IDLE (after last row handshakes); busy=1 outside IDLE.
REQ-012 SHALL, for chunk c (0..M-1), source output element j (bits j*ELEM_W +: ELEM_W) from col_nos slot N_IDX-N_OUT*(c+1)+j.
REQ-013 SHALL split each index into word = idx/N_UNITS and lane = idx%N_UNITS (shift/mask), registered in pipeline stage 1.
REQ-014 SHALL read mem[word] in stage 2 and select lane r from bits (N_UNITS-1-r)*ELEM_W +: ELEM_W in stage 3 (registered output_row).
REQ-015 SHALL treat index 32'hFFFFFFFF as invalid: element outputs zero, memory content ignored.
REQ-016 SHALL issue one chunk per cycle; with out_ready held 1, first out_valid occurs 3 cycles after the accept edge and M rows emerge on consecutive cycles.
REQ-017 SHALL stall all pipeline stages and hold output_row/out_valid/out_last stable while out_valid=1 and out_ready=0.
REQ-018 SHALL assert out_last with the row of chunk M-1, and pulse done the cycle after that row handshakes.
REQ-019 SHALL perform writes every cycle wr_en=1 regardless of state; a same-cycle read of wr_addr returns the old word (read-first).
REQ-020 SHALL accept a new start in the cycle done pulses (busy=0 then).

Reset
REQ-021 SHALL, on rst_n=0 at any time, return FSM to IDLE and clear out_valid, out_last, done, busy, output_row and pipeline valid bits to 0 asynchronously; memory contents are not reset.
REQ-022 SHALL discard any in-flight job on reset; no rows from it appear after rst_n rises.

Configuration
REQ-023 SHALL honour macro P_EMAP_GATHER_BOUNDS_CHECK_EN.
REQ-024 With it defined: valid index with word >= DEPTH yields zero element and sets sticky output oob_err (1 bit, cleared by reset or job accept).
REQ-025 Without it: no oob_err port; word address is truncated to clog2(DEPTH) bits (wraps).

Verification
REQ-026 Defaults, mem[2]={A0..A7} lane0 MSB, slots 31..16 = 16,17,...,23,16,..., M=1, ready=1 -> one row, element15=A0(lane0), out_last=1, out_valid 3 cycles after accept, then done.
REQ-027 M=2, slots 15..0 = 0xFFFFFFFF -> second row all zero, first row per mapping, rows on consecutive cycles.
REQ-028 M=2, out_ready low 4 cycles on first row -> row held unchanged, no loss, second row follows after handshake.
REQ-029 no_of_multiples=0 and =7 -> 1 and 2 rows respectively; start during busy -> ignored.
REQ-030 rst_n low mid-ISSUE -> outputs 0 immediately, no further rows, new job afterwards correct.
REQ-031 With P_EMAP_GATHER_BOUNDS_CHECK_EN, index 8200 (word 1025) -> element 0, oob_err=1; without, element from mem[1].
